// File: rtl/intc_gen.sv
// intc_gen: parametrised interrupt controller. Resynchronises NUM_SRC lines, latches
// them per source as rising-edge or level, masks them and raises one registered IRQ.
module intc_gen #(
    parameter int          NUM_SRC    = 11,
    parameter int          SYNC_DEPTH = 2,
    parameter logic [31:0] RST_MASK   = 32'h0,
    parameter logic [31:0] RST_MODE   = 32'h0
) (
    input  logic               i_clk,
    input  logic               i_rst_sync,
    input  logic               i_en,
    input  logic [31:0]        i_wb_regs_adr,
    input  logic               i_wb_intc_cyc,
    input  logic               i_wb_intc_stb,
    input  logic               i_wb_regs_we,
    input  logic [3:0]         i_wb_regs_sel,
    input  logic [31:0]        i_wb_regs_dat_wr,
    output logic               o_wb_intc_ack,
    output logic               o_wb_intc_err,
    output logic               o_wb_intc_stall,
    output logic [31:0]        o_wb_intc_dat_rd,
    input  logic [NUM_SRC-1:0] i_int_source,
    output logic               o_mips_hw_int
);

    localparam logic [1:0] REG_ISTAT = 2'd0;
    localparam logic [1:0] REG_IMASK = 2'd1;
    localparam logic [1:0] REG_IMODE = 2'd2;
    localparam int         CHAIN_W   = SYNC_DEPTH * NUM_SRC;

    logic [CHAIN_W-1:0] r_sync_chain;
    logic [NUM_SRC-1:0] r_sync_d;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_imask;
    logic [NUM_SRC-1:0] r_imode;
    logic               r_ack;
    logic               r_err;
    logic               r_stall;
    logic               r_irq;
    logic [31:0]        r_dat_rd;

    logic [NUM_SRC-1:0] w_sync_out;
    logic [NUM_SRC-1:0] w_set;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_masked;
    logic [NUM_SRC-1:0] w_pending_next;
    logic [NUM_SRC-1:0] w_lane_n;
    logic [NUM_SRC-1:0] w_wdat_n;
    logic [NUM_SRC-1:0] w_imask_next;
    logic [NUM_SRC-1:0] w_imode_next;
    logic [31:0]        w_lane;
    logic [31:0]        w_stat32;
    logic [31:0]        w_mask32;
    logic [31:0]        w_mode32;
    logic [31:0]        w_ivec32;
    logic [31:0]        w_rd_word;
    logic [4:0]         w_low_idx;
    logic [1:0]         w_reg;
    logic               w_accept;
    logic               w_sel_ok;
    logic               w_valid;
    logic               w_do_read;
    logic               w_do_write;
    logic               w_unused;

    genvar gi;

    // Byte-lane expansion of SEL, used for write merging and read masking alike.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi*8 +: 8] = {8{i_wb_regs_sel[gi]}};
        end
    endgenerate

    // Registers are NUM_SRC wide; bits above NUM_SRC read as zero.
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ext
            if (gi < NUM_SRC) begin : g_src
                assign w_stat32[gi] = w_masked[gi];
                assign w_mask32[gi] = r_imask[gi];
                assign w_mode32[gi] = r_imode[gi];
            end else begin : g_pad
                assign w_stat32[gi] = 1'b0;
                assign w_mask32[gi] = 1'b0;
                assign w_mode32[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_reg      = i_wb_regs_adr[3:2];
    assign w_accept   = i_wb_intc_cyc & i_wb_intc_stb & ~r_stall & i_en;
    assign w_sel_ok   = ((i_wb_regs_sel == 4'b1111) && (i_wb_regs_adr[1:0] == 2'b00)) ||
                        (((i_wb_regs_sel == 4'b0011) || (i_wb_regs_sel == 4'b1100)) &&
                         !i_wb_regs_adr[0]);
    assign w_valid    = (i_wb_regs_adr[11:4] == 8'd0) && w_sel_ok;
    assign w_do_read  = w_accept & w_valid & ~i_wb_regs_we;
    assign w_do_write = w_accept & w_valid & i_wb_regs_we;

    assign w_lane_n = w_lane[NUM_SRC-1:0];
    assign w_wdat_n = i_wb_regs_dat_wr[NUM_SRC-1:0];

    assign w_sync_out = r_sync_chain[CHAIN_W-1 -: NUM_SRC];
    assign w_masked   = r_pending & r_imask;

    // Level sources set on every high cycle; edge sources only on a 0->1 of the
    // synchronised line, so a mode switch while high does not retrigger.
    assign w_set = w_sync_out & (r_imode | ~r_sync_d);
    assign w_clr = (w_do_write && (w_reg == REG_ISTAT)) ? (w_lane_n & ~w_wdat_n) : '0;

    assign w_pending_next = (r_pending & ~w_clr) | w_set;

    assign w_imask_next = (r_imask & ~w_lane_n) | (w_wdat_n & w_lane_n);
    assign w_imode_next = (r_imode & ~w_lane_n) | (w_wdat_n & w_lane_n);

    always_comb begin
        w_low_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                w_low_idx = 5'(i);
            end
        end
    end

    assign w_ivec32 = {(|w_masked), 26'd0, w_low_idx};

    always_comb begin
        w_rd_word = '0;
        case (w_reg)
            REG_ISTAT: w_rd_word = w_stat32;
            REG_IMASK: w_rd_word = w_mask32;
            REG_IMODE: w_rd_word = w_mode32;
            default:   w_rd_word = w_ivec32;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_sync) begin
            r_sync_chain <= '0;
        end else if (i_en) begin
            r_sync_chain <= {r_sync_chain[CHAIN_W-NUM_SRC-1:0], i_int_source};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_sync) begin
            r_sync_d  <= '0;
            r_pending <= '0;
            r_imask   <= RST_MASK[NUM_SRC-1:0];
            r_imode   <= RST_MODE[NUM_SRC-1:0];
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_stall   <= 1'b0;
            r_irq     <= 1'b0;
            r_dat_rd  <= '0;
        end else if (i_en) begin
            r_sync_d  <= w_sync_out;
            r_pending <= w_pending_next;
            r_irq     <= |w_masked;
            r_ack     <= w_accept & w_valid;
            r_err     <= w_accept & ~w_valid;
            r_stall   <= w_accept;
            if (w_do_read) begin
                r_dat_rd <= w_rd_word & w_lane;
            end
            if (w_do_write && (w_reg == REG_IMASK)) begin
                r_imask <= w_imask_next;
            end
            if (w_do_write && (w_reg == REG_IMODE)) begin
                r_imode <= w_imode_next;
            end
        end
    end

    assign o_wb_intc_ack    = r_ack;
    assign o_wb_intc_err    = r_err;
    assign o_wb_intc_stall  = r_stall;
    assign o_wb_intc_dat_rd = r_dat_rd;
    assign o_mips_hw_int    = r_irq;

    // High-order address bits are decoded outside; upper write bits may exceed NUM_SRC.
    assign w_unused = ^{i_wb_regs_adr[31:12], i_wb_regs_dat_wr};

endmodule

// File: tb/tb_intc_gen.sv
// tb_intc_gen: directed scenarios plus randomized bus/source traffic, checked
// against a cycle-level behavioural model of the interrupt controller.
module tb_intc_gen;

    localparam int          N     = 11;
    localparam int          D     = 2;
    localparam logic [31:0] RMASK = 32'h0000_00A5;
    localparam logic [31:0] RMODE = 32'h0000_0102;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b1;
    logic [31:0]   adr = '0;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we  = 1'b0;
    logic [3:0]    sel = '0;
    logic [31:0]   dwr = '0;
    logic [N-1:0]  src = '0;
    logic          ack, err, stall, irq;
    logic [31:0]   drd;

    int n_tests = 0;
    int n_fail  = 0;

    intc_gen #(.NUM_SRC(N), .SYNC_DEPTH(D), .RST_MASK(RMASK), .RST_MODE(RMODE)) dut (
        .i_clk(clk), .i_rst_sync(rst), .i_en(en),
        .i_wb_regs_adr(adr), .i_wb_intc_cyc(cyc), .i_wb_intc_stb(stb),
        .i_wb_regs_we(we), .i_wb_regs_sel(sel), .i_wb_regs_dat_wr(dwr),
        .o_wb_intc_ack(ack), .o_wb_intc_err(err), .o_wb_intc_stall(stall),
        .o_wb_intc_dat_rd(drd), .i_int_source(src), .o_mips_hw_int(irq)
    );

    always #5 clk = ~clk;

    // Behavioural model: a queue delays the source by the resync depth, and bus
    // accesses are applied at the edge that accepts them.
    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_pend, m_mask, m_mode, m_act, m_now, m_prev, m_clr, m_mode_old;
    logic         m_irq, m_ack, m_err, m_stall, m_acc, m_ok;
    logic [31:0]  m_rdat, m_word, m_lane;

    always @(posedge clk) begin
        if (rst) begin
            m_pend = '0; m_mask = RMASK[N-1:0]; m_mode = RMODE[N-1:0];
            m_irq = 0; m_ack = 0; m_err = 0; m_stall = 0; m_rdat = '0;
            m_hist.delete();
            for (int k = 0; k <= D; k++) m_hist.push_back('0);
        end else if (en) begin
            m_acc = cyc && stb && !m_stall;
            m_ok  = (adr[11:4] == 8'd0) &&
                    ((sel == 4'hF && adr[1:0] == 2'b00) || ((sel == 4'h3 || sel == 4'hC) && !adr[0]));
            for (int b = 0; b < 4; b++) m_lane[b*8 +: 8] = {8{sel[b]}};
            m_act = m_pend & m_mask;
            m_irq = (m_act != '0);
            m_mode_old = m_mode;
            if (m_acc && m_ok && !we) begin
                case (adr[3:2])
                    2'd0: m_word = 32'(m_act);
                    2'd1: m_word = 32'(m_mask);
                    2'd2: m_word = 32'(m_mode);
                    default: begin
                        m_word = '0;
                        for (int k = 0; k < N; k++) if (m_act[k]) begin m_word = 32'h8000_0000 | 32'(k); break; end
                    end
                endcase
                m_rdat = m_word & m_lane;
            end
            m_clr = '0;
            if (m_acc && m_ok && we) begin
                case (adr[3:2])
                    2'd0: m_clr = m_lane[N-1:0] & ~dwr[N-1:0];
                    2'd1: m_mask = (m_mask & ~m_lane[N-1:0]) | (dwr[N-1:0] & m_lane[N-1:0]);
                    2'd2: m_mode = (m_mode & ~m_lane[N-1:0]) | (dwr[N-1:0] & m_lane[N-1:0]);
                    default: ;
                endcase
            end
            m_now  = m_hist[D-1];
            m_prev = m_hist[D];
            for (int k = 0; k < N; k++) begin
                if (m_now[k] && (m_mode_old[k] || !m_prev[k])) m_pend[k] = 1'b1;
                else if (m_clr[k]) m_pend[k] = 1'b0;
            end
            m_hist.push_front(src);
            void'(m_hist.pop_back());
            m_ack = m_acc && m_ok; m_err = m_acc && !m_ok; m_stall = m_acc;
        end
    end

    // Bus driver: called at a negedge, returns at the negedge of the ACK/ERR cycle.
    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] s, input logic [31:0] wd,
                       output logic ack_o, output logic err_o, output logic [31:0] rd_o);
        adr = a; we = w; sel = s; dwr = wd; cyc = 1'b1; stb = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ack || err) break;
        end
        ack_o = ack; err_o = err; rd_o = drd;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        $display("[TB] %s adr=%08h sel=%b wd=%08h ack=%0b err=%0b rd=%08h", w ? "WR" : "RD", a, s, wd, ack_o, err_o, rd_o);
    endtask

    task automatic test_reset();
        logic a, e; logic [31:0] r;
        rst = 1'b1; en = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if ({ack, err, stall, irq} !== 4'b0) begin n_fail++; $display("FAIL rst_ctl got=%b want=0000", {ack, err, stall, irq}); end
        n_tests++; if (drd !== 32'h0) begin n_fail++; $display("FAIL rst_dat got=%08h want=00000000", drd); end
        // A request presented with reset must be dropped.
        cyc = 1'b1; stb = 1'b1; adr = 32'h4; sel = 4'hF;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_tests++; if ({ack, err} !== 2'b00) begin n_fail++; $display("FAIL rst_drop got=%b want=00", {ack, err}); end
        bus(32'h4, 0, 4'hF, 0, a, e, r);
        n_tests++; if ({a, e} !== 2'b10 || r !== RMASK) begin n_fail++; $display("FAIL rst_imask got=%b/%08h want=10/%08h", {a, e}, r, RMASK); end
        bus(32'h8, 0, 4'hF, 0, a, e, r);
        n_tests++; if ({a, e} !== 2'b10 || r !== RMODE) begin n_fail++; $display("FAIL rst_imode got=%b/%08h want=10/%08h", {a, e}, r, RMODE); end
        bus(32'hC, 0, 4'hF, 0, a, e, r);
        n_tests++; if ({a, e} !== 2'b10 || r !== 32'h0) begin n_fail++; $display("FAIL rst_ivec got=%b/%08h want=10/00000000", {a, e}, r); end
        bus(32'h10, 0, 4'hF, 0, a, e, r);
        n_tests++; if ({a, e} !== 2'b01) begin n_fail++; $display("FAIL rst_adr10 got=%b want=01", {a, e}); end
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL rst_err_hold got=%08h want=00000000", r); end
    endtask

    task automatic test_edge();
        logic a, e; logic [31:0] r;
        bus(32'h4, 1, 4'hF, 32'h7FF, a, e, r);
        bus(32'h8, 1, 4'hF, 32'h0, a, e, r);
        src = 11'h008;
        @(negedge clk);
        src = '0;
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_k1 got=%b want=0", irq); end
        for (int k = 2; k <= D + 3; k++) begin
            @(negedge clk);
            n_tests++; if (irq !== (k >= D + 2)) begin n_fail++; $display("FAIL edge_irq_k%0d got=%b want=%b", k, irq, k >= D + 2); end
        end
        bus(32'h0, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h008) begin n_fail++; $display("FAIL edge_istat got=%08h want=00000008", r); end
        bus(32'h0, 1, 4'hF, 32'h7F7, a, e, r);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL edge_irq_at_clr got=%b want=1", irq); end
        @(negedge clk);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL edge_irq_after_clr got=%b want=0", irq); end
        bus(32'h0, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL edge_istat_clr got=%08h want=00000000", r); end
    endtask

    task automatic test_level();
        logic a, e; logic [31:0] r;
        bus(32'h8, 1, 4'hF, 32'h020, a, e, r);
        src = 11'h020;
        repeat (D + 3) @(negedge clk);
        bus(32'h0, 1, 4'hF, 32'h7DF, a, e, r);
        bus(32'h0, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h020) begin n_fail++; $display("FAIL level_held got=%08h want=00000020", r); end
        src = '0;
        repeat (D + 3) @(negedge clk);
        bus(32'h0, 1, 4'hF, 32'h7DF, a, e, r);
        bus(32'h0, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL level_dropped got=%08h want=00000000", r); end
    endtask

    task automatic test_ivec();
        logic a, e; logic [31:0] r;
        bus(32'h8, 1, 4'hF, 32'h0, a, e, r);
        src = 11'h084;
        @(negedge clk);
        src = '0;
        repeat (D + 3) @(negedge clk);
        bus(32'h4, 1, 4'hF, 32'h080, a, e, r);
        bus(32'hC, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h8000_0007) begin n_fail++; $display("FAIL ivec_7 got=%08h want=80000007", r); end
        bus(32'h4, 1, 4'hF, 32'h084, a, e, r);
        bus(32'hC, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h8000_0002) begin n_fail++; $display("FAIL ivec_2 got=%08h want=80000002", r); end
        bus(32'h4, 1, 4'hF, 32'h0, a, e, r);
        bus(32'hC, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL ivec_none got=%08h want=00000000", r); end
    endtask

    task automatic test_set_beats_clear();
        logic a, e; logic [31:0] r;
        bus(32'h4, 1, 4'hF, 32'h7FF, a, e, r);
        bus(32'h0, 1, 4'hF, 32'h0, a, e, r);
        // Rise sampled at the next edge lands in pending exactly D edges later.
        src = 11'h002;
        repeat (D) @(negedge clk);
        bus(32'h0, 1, 4'hF, 32'h7FD, a, e, r);
        src = '0;
        bus(32'h0, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h002) begin n_fail++; $display("FAIL set_beats_clr got=%08h want=00000002", r); end
        bus(32'h4, 1, 4'hC, 32'hFFFF_0000, a, e, r);
        bus(32'h4, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h7FF) begin n_fail++; $display("FAIL hw_upper got=%08h want=000007ff", r); end
        bus(32'h6, 1, 4'h3, 32'h0000_0123, a, e, r);
        bus(32'h4, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h123) begin n_fail++; $display("FAIL hw_lower got=%08h want=00000123", r); end
        bus(32'h4, 0, 4'h3, 0, a, e, r);
        n_tests++; if (r !== 32'h123) begin n_fail++; $display("FAIL hw_read got=%08h want=00000123", r); end
    endtask

    task automatic test_errors_en();
        logic a, e; logic [31:0] r, held;
        bus(32'h4, 1, 4'h6, 32'h0, a, e, r);
        n_tests++; if ({a, e} !== 2'b01 || r !== 32'h123) begin n_fail++; $display("FAIL err_sel0110 got=%b/%08h want=01/00000123", {a, e}, r); end
        bus(32'h5, 1, 4'hF, 32'h0, a, e, r);
        n_tests++; if ({a, e} !== 2'b01) begin n_fail++; $display("FAIL err_adr01 got=%b want=01", {a, e}); end
        bus(32'h4, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h123) begin n_fail++; $display("FAIL err_nochange got=%08h want=00000123", r); end
        bus(32'h4, 1, 4'hF, 32'h7FF, a, e, r);
        bus(32'h0, 1, 4'hF, 32'h0, a, e, r);
        @(negedge clk);
        held = drd;
        en = 1'b0;
        fork
            bus(32'h0, 0, 4'hF, 0, a, e, r);
            begin
                src = 11'h010;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    src = '0;
                    n_tests++; if ({ack, err, stall, irq} !== 4'b0 || drd !== held) begin n_fail++; $display("FAIL en_hold_%0d got=%b/%08h want=0000/%08h", k, {ack, err, stall, irq}, drd, held); end
                end
                en = 1'b1;
            end
        join
        n_tests++; if ({a, e} !== 2'b10 || r !== 32'h0) begin n_fail++; $display("FAIL en_resume got=%b/%08h want=10/00000000", {a, e}, r); end
        repeat (D + 3) @(negedge clk);
        bus(32'h0, 0, 4'hF, 0, a, e, r);
        n_tests++; if (r !== 32'h0) begin n_fail++; $display("FAIL en_pulse_lost got=%08h want=00000000", r); end
    endtask

    task automatic test_random();
        logic a, e; logic [31:0] r;
        logic [31:0] adr_tab[10];
        logic [3:0]  sel_tab[7];
        adr_tab = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h2, 32'h6, 32'hA, 32'hE, 32'h10, 32'h5};
        sel_tab = '{4'hF, 4'hF, 4'hF, 4'h3, 4'hC, 4'h6, 4'h1};
        for (int t = 0; t < 80; t++) begin
            src = N'($urandom);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
            bus(adr_tab[$urandom_range(0, 9)], 1'($urandom), sel_tab[$urandom_range(0, 6)], $urandom, a, e, r);
            n_tests++; if ({a, e} !== {m_ack, m_err}) begin n_fail++; $display("FAIL rnd%0d_resp got=%b want=%b", t, {a, e}, {m_ack, m_err}); end
            n_tests++; if (r !== m_rdat) begin n_fail++; $display("FAIL rnd%0d_data got=%08h want=%08h", t, r, m_rdat); end
            n_tests++; if (irq !== m_irq) begin n_fail++; $display("FAIL rnd%0d_irq got=%b want=%b", t, irq, m_irq); end
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_stall got=%b want=1", t, stall); end
        end
        src = '0;
    endtask

    initial begin
        test_reset();
        test_edge();
        test_level();
        test_ivec();
        test_set_beats_clear();
        test_errors_en();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
